mcht_dec_gen: RTL and testbench
===============================

Name: mcht_dec_gen

Overview:
Parametrised single-clock Manchester frame decoder, the successor to the fixed 16-bit decoder. It oversamples RXD at pHALF_T clocks per half-bit and locks to a start symbol. Each data bit is recovered from its mid-bit transition, checked against a tolerance window. Decoded words are delivered over a valid/ready handshake, with code-violation and overflow reporting. It sits between the line receiver pad and the message consumer in the same clock domain.

Parameters:
pMSG_LEN, 16, data bits per frame (2..64)
pHALF_T, 4, clocks per half-bit period (>=4, even)
pTOL, 1, allowed edge jitter in clocks (pTOL < pHALF_T/2)
pIDLE_T, 12, consecutive high samples required to arm/re-arm (>= 2*pHALF_T+pTOL+1)
pMSB_FIRST, 0, 1: first received bit goes to MSG_DATA[pMSG_LEN-1]; 0: first bit goes to bit 0
pPOL, 0, 0: rising mid-bit edge = 1; 1: rising mid-bit edge = 0

Ports:
CLK100M  input  1  oversample clock; single clock domain
RST_N  input  1  asynchronous active-low reset
RXD  input  1  serial line, idle high, asynchronous to CLK100M
MSG_DATA  output  pMSG_LEN  decoded word, stable while MSG_VLD=1
MSG_VLD  output  1  word available
MSG_RDY  input  1  consumer accepts; transfer when MSG_VLD & MSG_RDY
ERR_CODE  output  1  one-cycle pulse: timing/code violation, frame aborted
ERR_OVF  output  1  one-cycle pulse: completed frame dropped, holding word full
BUSY  output  1  high in START, BIT, TAIL states

Behaviour:
- Reset values: MSG_DATA=0, MSG_VLD=0, ERR_CODE=0, ERR_OVF=0, BUSY=0, state=IDLE, sync flops=3'b111, idle counter=0, half-bit counter=0, bit index=0.
- Sync: 3-flop shift s[2:0]; edge = s[1]^s[2]; level = s[1]. All timing is referenced to edge-pulse cycles.
- Idle counter: +1 per cycle while level=1, saturating; cleared on level=0. armed = count >= pIDLE_T.
- Half-bit counter T: cleared on the cycle an accepted edge is seen, otherwise +1, saturating at 2*pHALF_T+pTOL+1.
- States:
  - IDLE: go to ARMED when armed.
  - ARMED: falling edge -> START, T=0.
  - START: rising edge with T in [pHALF_T-pTOL, pHALF_T+pTOL] -> BIT (this edge is the mid-bit reference, T=0, index=0). Rising edge outside the window, or T saturating -> ERR_CODE, IDLE.
  - BIT: edges with T < (3*pHALF_T)/2 are boundary edges and are ignored. An edge with T in [2*pHALF_T-pTOL, 2*pHALF_T+pTOL] is a mid-bit edge: bit = level XOR pPOL (after edge), stored at the index per pMSB_FIRST, index+1, T=0. An edge with T in [3*pHALF_T/2, 2*pHALF_T-pTOL) or T saturated -> ERR_CODE, IDLE; partial word discarded. After bit pMSG_LEN-1 -> TAIL and deliver.
  - TAIL: wait for armed -> IDLE. A new falling edge cannot start a frame until re-armed.
- Deliver, in the cycle after the last mid-bit edge:
  - MSG_VLD=0, or MSG_VLD=1 with MSG_RDY=1 in that cycle: MSG_DATA loads the new word, MSG_VLD=1.
  - MSG_VLD=1 with MSG_RDY=0: ERR_OVF pulses, the new word is dropped, and the held word is unchanged.
- Handshake: MSG_VLD clears the cycle after MSG_VLD & MSG_RDY, unless a simultaneous load occurs. MSG_DATA does not change while MSG_VLD=1 except on that simultaneous load.
- Latency: MSG_VLD rises exactly 1 clock after the edge pulse of the last mid-bit; that edge pulse occurs 2 clocks after the RXD change.
- ERR_CODE and ERR_OVF never assert in the same cycle. Each is exactly one clock wide per event.
- Reset mid-frame: all state returns to reset values; the receiver must re-arm (pIDLE_T high) before accepting a frame.

Test Plan:
Defaults except pMSG_LEN=8. Half-bit = 4 clocks.
- Clean frame 0xA5, LSB-first, idle 16 high before -> one MSG_VLD pulse train, MSG_DATA=8'hA5, no ERR_*, MSG_VLD rises 1 clk after last mid-bit edge pulse.
- Same frame with pMSB_FIRST=1 and pPOL=1 -> MSG_DATA=8'h5A (inverted, reversed = ~0xA5 reversed = 8'h5A).
- Jitter: every mid-bit edge shifted +1 then -1 clk alternately -> MSG_DATA=8'hA5; any shift of +2 -> ERR_CODE one pulse, MSG_VLD stays 0, BUSY falls.
- Missing mid-bit transition at bit 3 (line held 12 clks) -> ERR_CODE at T saturation, return IDLE; next clean frame 0x3C after 16 idle -> MSG_DATA=8'h3C.
- Backpressure: MSG_RDY=0, send 0x11 then 0x22 -> MSG_DATA stays 8'h11, one ERR_OVF pulse. Then MSG_RDY=1 -> MSG_VLD drops after one transfer.
- Assert RST_N low mid-bit 4, release, send 0x81 with only 6 idle clocks -> ignored. With 16 idle clocks -> 8'h81.

Source files
------------

// File: rtl/mcht_dec_gen.sv
// Parametrised Manchester frame decoder: oversampled RXD, start-symbol lock,
// mid-bit sampling within a jitter window, valid/ready word delivery.
module mcht_dec_gen #(
    parameter int unsigned pMSG_LEN   = 16,
    parameter int unsigned pHALF_T    = 4,
    parameter int unsigned pTOL       = 1,
    parameter int unsigned pIDLE_T    = 12,
    parameter int unsigned pMSB_FIRST = 0,
    parameter int unsigned pPOL       = 0
) (
    input  logic                CLK100M,
    input  logic                RST_N,
    input  logic                RXD,
    output logic [pMSG_LEN-1:0] MSG_DATA,
    output logic                MSG_VLD,
    input  logic                MSG_RDY,
    output logic                ERR_CODE,
    output logic                ERR_OVF,
    output logic                BUSY
);

    localparam int unsigned TW = $clog2(2*pHALF_T + pTOL + 2);
    localparam int unsigned IW = $clog2(pIDLE_T + 1);
    localparam int unsigned XW = $clog2(pMSG_LEN);

    localparam logic [TW-1:0] T_SAT    = TW'(2*pHALF_T + pTOL + 1);
    localparam logic [TW-1:0] T_SW_LO  = TW'(pHALF_T - pTOL);
    localparam logic [TW-1:0] T_SW_HI  = TW'(pHALF_T + pTOL);
    localparam logic [TW-1:0] T_BND    = TW'((3*pHALF_T)/2);
    localparam logic [TW-1:0] T_MW_LO  = TW'(2*pHALF_T - pTOL);
    localparam logic [TW-1:0] T_MW_HI  = TW'(2*pHALF_T + pTOL);
    localparam logic [IW-1:0] I_ARM    = IW'(pIDLE_T);
    localparam logic [XW-1:0] LAST_IDX = XW'(pMSG_LEN - 1);
    localparam logic          POL      = (pPOL != 0);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_START, S_BIT, S_TAIL} state_t;

    state_t              state, state_n;
    logic [2:0]          sync;
    logic [IW-1:0]       idle_cnt;
    logic [TW-1:0]       t_cnt;
    logic [XW-1:0]       bit_idx, pos;
    logic [pMSG_LEN-1:0] word_q, word_nxt;
    logic                edge_p, lvl, rise, fall, armed, t_sat;
    logic                in_start_win, in_mid_win, is_bound;
    logic                t_clr, take_bit, bit_start, done, err_n;

    assign edge_p       = sync[1] ^ sync[2];
    assign lvl          = sync[1];
    assign rise         = edge_p & lvl;
    assign fall         = edge_p & ~lvl;
    assign armed        = (idle_cnt >= I_ARM);
    assign t_sat        = (t_cnt == T_SAT);
    assign in_start_win = (t_cnt >= T_SW_LO) && (t_cnt <= T_SW_HI);
    assign in_mid_win   = (t_cnt >= T_MW_LO) && (t_cnt <= T_MW_HI);
    assign is_bound     = (t_cnt < T_BND);
    assign BUSY         = (state == S_START) || (state == S_BIT) || (state == S_TAIL);

    always_comb begin
        pos           = (pMSB_FIRST != 0) ? (LAST_IDX - bit_idx) : bit_idx;
        word_nxt      = word_q;
        word_nxt[pos] = lvl ^ POL;
    end

    always_comb begin
        state_n   = state;
        t_clr     = 1'b0;
        take_bit  = 1'b0;
        bit_start = 1'b0;
        done      = 1'b0;
        err_n     = 1'b0;
        case (state)
            S_IDLE:  if (armed) state_n = S_ARMED;
            S_ARMED: begin
                if (fall) begin
                    state_n = S_START;
                    t_clr   = 1'b1;
                end else if (!armed) begin
                    state_n = S_IDLE;
                end
            end
            S_START: begin
                if (t_sat || (rise && !in_start_win)) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else if (rise) begin
                    state_n   = S_BIT;
                    t_clr     = 1'b1;
                    bit_start = 1'b1;
                end
            end
            S_BIT: begin
                if (t_sat) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else if (edge_p && !is_bound) begin
                    if (in_mid_win) begin
                        take_bit = 1'b1;
                        t_clr    = 1'b1;
                        if (bit_idx == LAST_IDX) begin
                            done    = 1'b1;
                            state_n = S_TAIL;
                        end
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            S_TAIL:  if (armed) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // t_cnt restarts at 1 so that its value on an edge equals the spacing
    // in clocks from the previous accepted edge.
    always_ff @(posedge CLK100M or negedge RST_N) begin
        if (!RST_N) begin
            sync     <= 3'b111;
            idle_cnt <= '0;
            t_cnt    <= '0;
            bit_idx  <= '0;
            word_q   <= '0;
            state    <= S_IDLE;
        end else begin
            sync  <= {sync[1:0], RXD};
            state <= state_n;
            if (!lvl)
                idle_cnt <= '0;
            else if (!armed)
                idle_cnt <= idle_cnt + IW'(1);
            if (t_clr)
                t_cnt <= TW'(1);
            else if (!t_sat)
                t_cnt <= t_cnt + TW'(1);
            if (bit_start) begin
                bit_idx <= '0;
                word_q  <= '0;
            end else if (take_bit) begin
                bit_idx <= bit_idx + XW'(1);
                word_q  <= word_nxt;
            end
        end
    end

    always_ff @(posedge CLK100M or negedge RST_N) begin
        if (!RST_N) begin
            MSG_DATA <= '0;
            MSG_VLD  <= 1'b0;
            ERR_CODE <= 1'b0;
            ERR_OVF  <= 1'b0;
        end else begin
            ERR_CODE <= err_n;
            ERR_OVF  <= done && MSG_VLD && !MSG_RDY;
            if (done && (!MSG_VLD || MSG_RDY)) begin
                MSG_DATA <= word_nxt;
                MSG_VLD  <= 1'b1;
            end else if (MSG_VLD && MSG_RDY) begin
                MSG_VLD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mcht_dec_gen.sv
// Bench for mcht_dec_gen: two decoders (LSB/pPOL=0 and MSB/pPOL=1) share one
// line driven by a waveform builder; outcomes are predicted from the frame rules.
module tb_mcht_dec_gen;

    localparam int unsigned H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rdy = 1'b1;
    logic [7:0] d0, d1;
    logic       v0, v1, ec0, ec1, eo0, eo1, b0, b1;

    always #5 clk = ~clk;

    mcht_dec_gen #(.pMSG_LEN(8), .pHALF_T(4), .pTOL(1), .pIDLE_T(12),
                   .pMSB_FIRST(0), .pPOL(0)) u_dec_lsb (
        .CLK100M(clk), .RST_N(rst_n), .RXD(rxd), .MSG_DATA(d0), .MSG_VLD(v0),
        .MSG_RDY(rdy), .ERR_CODE(ec0), .ERR_OVF(eo0), .BUSY(b0));

    mcht_dec_gen #(.pMSG_LEN(8), .pHALF_T(4), .pTOL(1), .pIDLE_T(12),
                   .pMSB_FIRST(1), .pPOL(1)) u_dec_msb (
        .CLK100M(clk), .RST_N(rst_n), .RXD(rxd), .MSG_DATA(d1), .MSG_VLD(v1),
        .MSG_RDY(rdy), .ERR_CODE(ec1), .ERR_OVF(eo1), .BUSY(b1));

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned chg_cyc = 0;
    int          jit[9];
    logic        cur;

    int unsigned rise0 = 0, rise1 = 0, rc0 = 0, rc1 = 0;
    int unsigned ecn0 = 0, ecn1 = 0, ovn0 = 0, ovn1 = 0;
    int unsigned bzn0 = 0, bzn1 = 0, both_n = 0;
    logic [7:0]  cap0 = '0, cap1 = '0;
    logic        pv0 = 1'b0, pv1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (ec0) ecn0++;
            if (ec1) ecn1++;
            if (eo0) ovn0++;
            if (eo1) ovn1++;
            if (b0) bzn0++;
            if (b1) bzn1++;
            if ((ec0 && eo0) || (ec1 && eo1)) both_n++;
            if (v0 && !pv0) begin rise0++; rc0 = cyc; cap0 = d0; end
            if (v1 && !pv1) begin rise1++; rc1 = cyc; cap1 = d1; end
            pv0 = v0;
            pv1 = v1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] exp_msb_pol1(input logic [7:0] lv);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = ~lv[i];
        return r;
    endfunction

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rxd = v;
            if (i == 0) chg_cyc = cyc;
        end
    endtask

    task automatic clear_jit();
        for (int i = 0; i < 9; i++) jit[i] = 0;
    endtask

    // Start symbol and nb bits; the mid edge of the last bit is the next drive of cur.
    task automatic frame_body(input logic [7:0] lv, input int nb);
        logic p;
        drive(1'b0, int'(H) + jit[0]);
        p = 1'b1;
        for (int i = 0; i < nb; i++) begin
            if (p == lv[i]) begin
                drive(p, int'(H));
                drive(~p, int'(H) + jit[i+1]);
            end else begin
                drive(p, 2*int'(H) + jit[i+1]);
            end
            p = lv[i];
        end
        cur = p;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] lv, input int idle_n,
                             input int unsigned exp_rise, input int unsigned exp_ec,
                             input int unsigned exp_ov, input logic exp_busy);
        int unsigned r0, r1, e0, e1, o0, o1, z0, z1, mid;
        r0 = rise0; r1 = rise1; e0 = ecn0; e1 = ecn1;
        o0 = ovn0; o1 = ovn1; z0 = bzn0; z1 = bzn1;
        drive(1'b1, idle_n);
        frame_body(lv, 8);
        drive(cur, int'(H));
        mid = chg_cyc;
        drive(1'b1, 24);
        check_val({tag, "_rise0"}, rise0 - r0, exp_rise);
        check_val({tag, "_rise1"}, rise1 - r1, exp_rise);
        check_val({tag, "_ec0"}, ecn0 - e0, exp_ec);
        check_val({tag, "_ec1"}, ecn1 - e1, exp_ec);
        check_val({tag, "_ov0"}, ovn0 - o0, exp_ov);
        check_val({tag, "_ov1"}, ovn1 - o1, exp_ov);
        check_val({tag, "_busy0"}, (bzn0 != z0), exp_busy);
        check_val({tag, "_busy1"}, (bzn1 != z1), exp_busy);
        check_val({tag, "_idle0"}, b0, 1'b0);
        check_val({tag, "_idle1"}, b1, 1'b0);
        if (exp_rise != 0) begin
            check_val({tag, "_data0"}, cap0, lv);
            check_val({tag, "_data1"}, cap1, exp_msb_pol1(lv));
            check_val({tag, "_lat0"}, rc0 - mid, 3);
            check_val({tag, "_lat1"}, rc1 - mid, 3);
        end
    endtask

    initial begin
        logic [7:0]  lv;
        logic        ok;
        int unsigned r0, e0;

        clear_jit();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_data0", d0, 8'h00);
        check_val("rst_data1", d1, 8'h00);
        check_val("rst_vld", {v0, v1}, 2'b00);
        check_val("rst_err", {ec0, ec1, eo0, eo1}, 4'h0);
        check_val("rst_busy", {b0, b1}, 2'b00);
        @(posedge clk); #1; rst_n = 1'b1;

        run_frame("a5", 8'hA5, 16, 1, 0, 0, 1'b1);
        check_val("a5_lsb_const", cap0, 8'hA5);
        check_val("a5_msb_const", cap1, 8'h5A);

        for (int i = 1; i < 9; i++) jit[i] = (i % 2 == 1) ? 1 : -1;
        run_frame("jit", 8'hA5, 16, 1, 0, 0, 1'b1);
        clear_jit();
        jit[3] = 2;
        run_frame("jit2", 8'hA5, 16, 0, 1, 0, 1'b1);
        clear_jit();

        r0 = rise0; e0 = ecn0;
        drive(1'b1, 16);
        frame_body(8'h3C, 3);
        drive(cur, 12);
        drive(1'b1, 24);
        check_val("miss_ec", ecn0 - e0, 1);
        check_val("miss_rise", rise0 - r0, 0);
        check_val("miss_busy", b0, 1'b0);
        run_frame("3c", 8'h3C, 16, 1, 0, 0, 1'b1);

        rdy = 1'b0;
        run_frame("bp1", 8'h11, 16, 1, 0, 0, 1'b1);
        run_frame("bp2", 8'h22, 16, 0, 0, 1, 1'b1);
        check_val("bp_hold0", d0, 8'h11);
        check_val("bp_hold1", d1, exp_msb_pol1(8'h11));
        @(posedge clk); #1; rdy = 1'b1;
        @(negedge clk);
        check_val("bp_vld_xfer", {v0, v1}, 2'b11);
        @(negedge clk);
        check_val("bp_vld_drop", {v0, v1}, 2'b00);

        r0 = rise0; e0 = ecn0;
        drive(1'b1, 16);
        frame_body(8'hC3, 4);
        drive(cur, 3);
        @(posedge clk); #1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("mrst_data0", d0, 8'h00);
        check_val("mrst_busy", {b0, b1}, 2'b00);
        @(posedge clk); #1; rst_n = 1'b1;
        check_val("mrst_rise", rise0 - r0, 0);
        check_val("mrst_ec", ecn0 - e0, 0);
        run_frame("ign81", 8'h81, 6, 0, 0, 0, 1'b0);
        run_frame("ok81", 8'h81, 16, 1, 0, 0, 1'b1);

        for (int k = 0; k < 24; k++) begin
            lv = 8'($urandom);
            for (int i = 0; i < 9; i++) jit[i] = int'($urandom_range(2, 0)) - 1;
            if ($urandom_range(2, 0) == 0)
                jit[$urandom_range(8, 0)] = ($urandom_range(1, 0) == 1) ? 2 : -2;
            ok = 1'b1;
            for (int i = 0; i < 9; i++) if (jit[i] > 1 || jit[i] < -1) ok = 1'b0;
            run_frame($sformatf("rnd%0d", k), lv, 16, ok ? 1 : 0, ok ? 0 : 1, 0, 1'b1);
        end
        clear_jit();

        check_val("err_overlap", both_n, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
